// File: rtl/shift_rotate_unit.sv
// rtl/shift_rotate_unit.sv - multi-cycle shift/rotate engine, one bit position per clock
// Start/busy/done handshake; result and carry/zero/negative flags held until the next completion.
module shift_rotate_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int AMT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [2:0]            mode_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [AMT_WIDTH-1:0]  amount_i,
  input  logic                  carry_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  flag_carry_o,
  output logic                  flag_zero_o,
  output logic                  flag_negative_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [2:0] MODE_SHL = 3'b000;
  localparam logic [2:0] MODE_SHR = 3'b001;
  localparam logic [2:0] MODE_ASR = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;
  localparam logic [2:0] MODE_RCL = 3'b101;
  localparam logic [2:0] MODE_RCR = 3'b110;
  localparam logic [2:0] MODE_RSV = 3'b111;

  localparam logic [AMT_WIDTH-1:0] MAX_AMT = AMT_WIDTH'(DATA_WIDTH);
  localparam logic [AMT_WIDTH-1:0] ONE_AMT = AMT_WIDTH'(1);

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  c_q, c_d;
  logic [2:0]            mode_q, mode_d;
  logic [AMT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  carry_q, carry_d;
  logic                  zero_q, zero_d;
  logic                  neg_q, neg_d;

  logic [DATA_WIDTH-1:0] step_data;
  logic                  step_c;

  // Single 1-bit step of the latched operation; C is the running carry.
  always_comb begin
    step_data = sh_q;
    step_c    = c_q;
    case (mode_q)
      MODE_SHL: begin step_data = {sh_q[DATA_WIDTH-2:0], 1'b0};           step_c = sh_q[DATA_WIDTH-1]; end
      MODE_SHR: begin step_data = {1'b0, sh_q[DATA_WIDTH-1:1]};           step_c = sh_q[0];            end
      MODE_ASR: begin step_data = {sh_q[DATA_WIDTH-1], sh_q[DATA_WIDTH-1:1]}; step_c = sh_q[0];        end
      MODE_ROL: begin step_data = {sh_q[DATA_WIDTH-2:0], sh_q[DATA_WIDTH-1]}; step_c = sh_q[DATA_WIDTH-1]; end
      MODE_ROR: begin step_data = {sh_q[0], sh_q[DATA_WIDTH-1:1]};        step_c = sh_q[0];            end
      MODE_RCL: begin step_data = {sh_q[DATA_WIDTH-2:0], c_q};            step_c = sh_q[DATA_WIDTH-1]; end
      MODE_RCR: begin step_data = {c_q, sh_q[DATA_WIDTH-1:1]};            step_c = sh_q[0];            end
      default:  begin step_data = sh_q;                                   step_c = c_q;                end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    c_d      = c_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SHIFT;
          busy_d  = 1'b1;
          sh_d    = data_i;
          c_d     = carry_i;
          mode_d  = mode_i;
          // Reserved mode is a pass-through, so it simply runs zero steps.
          if (mode_i == MODE_RSV)      cnt_d = '0;
          else if (amount_i > MAX_AMT) cnt_d = MAX_AMT;
          else                         cnt_d = amount_i;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          sh_d  = step_data;
          c_d   = step_c;
          cnt_d = cnt_q - ONE_AMT;
        end else begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = sh_q;
          carry_d  = c_q;
          zero_d   = (sh_q == '0);
          neg_d    = sh_q[DATA_WIDTH-1];
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sh_q     <= '0;
      c_q      <= 1'b0;
      mode_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      c_q      <= c_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign result_o        = result_q;
  assign flag_carry_o    = carry_q;
  assign flag_zero_o     = zero_q;
  assign flag_negative_o = neg_q;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// tb/tb_shift_rotate_unit.sv - directed bench for shift_rotate_unit (DATA_WIDTH=8)
module tb_shift_rotate_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_i;
  logic [2:0] mode_i;
  logic [7:0] data_i;
  logic [3:0] amount_i;
  logic       carry_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] result_o;
  logic       flag_carry_o;
  logic       flag_zero_o;
  logic       flag_negative_o;

  int passed = 0;
  int total  = 0;

  shift_rotate_unit #(.DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .mode_i(mode_i), .data_i(data_i),
    .amount_i(amount_i), .carry_i(carry_i), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .flag_carry_o(flag_carry_o), .flag_zero_o(flag_zero_o),
    .flag_negative_o(flag_negative_o)
  );

  always #5 clk = ~clk;

  // Issues one op from the current cycle; returns edges from accept to done and busy cycles seen.
  task automatic issue(input logic [2:0] m, input logic [7:0] d, input logic [3:0] a,
                       input logic c, output int lat, output int busy_cnt);
    mode_i = m; data_i = d; amount_i = a; carry_i = c; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!done_o && lat < 40) begin
      if (busy_o) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start_i = 1'b0; mode_i = '0; data_i = '0; amount_i = '0; carry_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy_o, done_o, result_o, flag_carry_o, flag_zero_o, flag_negative_o} !== 13'h0)
      $display("FAIL reset_outputs got=%h want=0",
               {busy_o, done_o, result_o, flag_carry_o, flag_zero_o, flag_negative_o});
    else passed++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_rcl;
    int lat, bc;
    issue(3'b101, 8'hF0, 4'd1, 1'b0, lat, bc);
    total++; if (result_o !== 8'hE0) $display("FAIL rcl_result got=%h want=e0", result_o); else passed++;
    total++; if ({flag_carry_o, flag_negative_o, flag_zero_o} !== 3'b110)
      $display("FAIL rcl_flags got=%b want=110", {flag_carry_o, flag_negative_o, flag_zero_o}); else passed++;
    total++; if (lat != 2) $display("FAIL rcl_latency got=%0d want=2", lat); else passed++;
    total++; if (bc != 2) $display("FAIL rcl_busy_cycles got=%0d want=2", bc); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL rcl_busy_at_done got=%b want=0", busy_o); else passed++;
    @(posedge clk); #1;
    total++; if (done_o !== 1'b0) $display("FAIL rcl_done_pulse got=%b want=0", done_o); else passed++;
  endtask

  task automatic test_rotates;
    int lat, bc;
    issue(3'b011, 8'h81, 4'd4, 1'b0, lat, bc);
    total++; if (result_o !== 8'h18) $display("FAIL rol_result got=%h want=18", result_o); else passed++;
    total++; if ({flag_carry_o, flag_negative_o, flag_zero_o} !== 3'b000)
      $display("FAIL rol_flags got=%b want=000", {flag_carry_o, flag_negative_o, flag_zero_o}); else passed++;
    total++; if (lat != 5) $display("FAIL rol_latency got=%0d want=5", lat); else passed++;
    @(posedge clk); #1;
    issue(3'b100, 8'h01, 4'd1, 1'b0, lat, bc);
    total++; if (result_o !== 8'h80) $display("FAIL ror_result got=%h want=80", result_o); else passed++;
    total++; if ({flag_carry_o, flag_negative_o, flag_zero_o} !== 3'b110)
      $display("FAIL ror_flags got=%b want=110", {flag_carry_o, flag_negative_o, flag_zero_o}); else passed++;
    @(posedge clk); #1;
    issue(3'b110, 8'h02, 4'd2, 1'b1, lat, bc);
    total++; if ({result_o, flag_carry_o} !== {8'h40, 1'b1})
      $display("FAIL rcr_result got=%h/%b want=40/1", result_o, flag_carry_o); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_shifts;
    int lat, bc;
    issue(3'b010, 8'h80, 4'd3, 1'b1, lat, bc);
    total++; if (result_o !== 8'hF0) $display("FAIL asr_result got=%h want=f0", result_o); else passed++;
    total++; if ({flag_carry_o, flag_negative_o, flag_zero_o} !== 3'b010)
      $display("FAIL asr_flags got=%b want=010", {flag_carry_o, flag_negative_o, flag_zero_o}); else passed++;
    @(posedge clk); #1;
    issue(3'b001, 8'h01, 4'd1, 1'b0, lat, bc);
    total++; if (result_o !== 8'h00) $display("FAIL shr_result got=%h want=00", result_o); else passed++;
    total++; if ({flag_carry_o, flag_negative_o, flag_zero_o} !== 3'b101)
      $display("FAIL shr_flags got=%b want=101", {flag_carry_o, flag_negative_o, flag_zero_o}); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_clamp_ignore;
    int ndone = 0;
    int first = -1;
    mode_i = 3'b000; data_i = 8'hFF; amount_i = 4'd12; carry_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 16; i++) begin
      start_i = (i == 3);
      data_i  = (i == 3) ? 8'h01 : 8'hFF;
      @(posedge clk); #1;
      if (done_o) begin
        ndone++;
        if (first < 0) first = i;
      end
    end
    start_i = 1'b0;
    total++; if (ndone != 1) $display("FAIL clamp_done_count got=%0d want=1", ndone); else passed++;
    total++; if (first != 9) $display("FAIL clamp_latency got=%0d want=9", first); else passed++;
    total++; if ({result_o, flag_carry_o, flag_zero_o, flag_negative_o} !== {8'h00, 3'b110})
      $display("FAIL clamp_result got=%h/%b%b%b want=00/110", result_o, flag_carry_o, flag_zero_o, flag_negative_o);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    issue(3'b000, 8'h5A, 4'd0, 1'b1, lat, bc);
    total++; if ({result_o, flag_carry_o} !== {8'h5A, 1'b1})
      $display("FAIL amt0_result got=%h/%b want=5a/1", result_o, flag_carry_o); else passed++;
    total++; if (lat != 1) $display("FAIL amt0_latency got=%0d want=1", lat); else passed++;
    // Start raised in the cycle done_o is high.
    issue(3'b111, 8'h5A, 4'd5, 1'b1, lat, bc);
    total++; if ({result_o, flag_carry_o, flag_zero_o, flag_negative_o} !== {8'h5A, 3'b100})
      $display("FAIL rsv_result got=%h/%b%b%b want=5a/100", result_o, flag_carry_o, flag_zero_o, flag_negative_o);
    else passed++;
    total++; if (lat != 1) $display("FAIL b2b_latency got=%0d want=1", lat); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset;
    int lat, bc;
    mode_i = 3'b000; data_i = 8'h81; amount_i = 4'd6; carry_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if ({busy_o, done_o, result_o, flag_carry_o, flag_zero_o, flag_negative_o} !== 13'h0)
      $display("FAIL midreset_outputs got=%h want=0",
               {busy_o, done_o, result_o, flag_carry_o, flag_zero_o, flag_negative_o});
    else passed++;
    @(posedge clk); #1;
    total++; if (done_o !== 1'b0) $display("FAIL midreset_no_done got=%b want=0", done_o); else passed++;
    issue(3'b100, 8'h01, 4'd1, 1'b0, lat, bc);
    total++; if ({result_o, flag_carry_o, flag_negative_o, lat} !== {8'h80, 1'b1, 1'b1, 32'd2})
      $display("FAIL postreset_op got=%h/%b%b lat=%0d want=80/11 lat=2", result_o, flag_carry_o, flag_negative_o, lat);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_rcl;
    test_rotates;
    test_shifts;
    test_clamp_ignore;
    test_back_to_back;
    test_mid_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
